exmm_mem_ctrl: RTL and testbench

EX/MEM pipeline register plus memory-stage data-access controller for the pipelined MIPS core. It latches execute-stage results on a pipeline advance and presents them to the memory stage. For loads and stores it runs a request/dhit handshake with the data cache and raises a stall toward the hazard unit until the access completes. It also holds load data for the MEM/WB latch and counts data-stall cycles.

---
 rtl/exmm_mem_ctrl.sv | 140 ++++++++++++++
 tb/tb_exmm_mem_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exmm_mem_ctrl.sv
// EX/MEM pipeline latch with the memory-stage request/dhit handshake toward the
// data cache, a held copy of the last load result and a saturating stall counter.
module exmm_mem_ctrl #(
    parameter int OPW  = 6,
    parameter int CNTW = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            en,
    input  logic            flush,
    input  logic [OPW-1:0]  ex_opfunc,
    input  logic [1:0]      ex_MemtoReg,
    input  logic            ex_RegWEN,
    input  logic            ex_dWENi,
    input  logic            ex_dRENi,
    input  logic            ex_equal,
    input  logic            ex_halt,
    input  logic [4:0]      ex_rd,
    input  logic [31:0]     ex_portB,
    input  logic [31:0]     ex_npc,
    input  logic [31:0]     ex_ALUOut,
    input  logic [31:0]     ex_store,
    output logic [OPW-1:0]  mm_opfunc,
    output logic [1:0]      mm_MemtoReg,
    output logic            mm_RegWEN,
    output logic            mm_dWENi,
    output logic            mm_dRENi,
    output logic            mm_equal,
    output logic            mm_halt,
    output logic [4:0]      mm_rd,
    output logic [31:0]     mm_portB,
    output logic [31:0]     mm_npc,
    output logic [31:0]     mm_ALUOut,
    output logic [31:0]     mm_store,
    output logic            dmemREN,
    output logic            dmemWEN,
    output logic [31:0]     dmemaddr,
    output logic [31:0]     dmemstore,
    input  logic            dhit,
    input  logic [31:0]     dmemload,
    output logic [31:0]     mm_loaddata,
    output logic            mm_stall,
    output logic [CNTW-1:0] stall_cnt
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [31:0]     r_loaddata;
    logic [CNTW-1:0] r_stall_cnt;
    logic            w_advance;
    logic            w_load_hit;
    logic            w_new_dren;
    logic            w_new_dwen;

    assign w_advance  = en & ~mm_stall;
    assign w_load_hit = (r_state == REQ) & dhit & mm_dRENi;
    // A write wins over a read when EX asserts both.
    assign w_new_dwen = ~flush & ex_dWENi;
    assign w_new_dren = ~flush & ex_dRENi & ~ex_dWENi;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mm_opfunc   <= '0;
            mm_MemtoReg <= '0;
            mm_RegWEN   <= 1'b0;
            mm_dWENi    <= 1'b0;
            mm_dRENi    <= 1'b0;
            mm_equal    <= 1'b0;
            mm_halt     <= 1'b0;
            mm_rd       <= '0;
            mm_portB    <= '0;
            mm_npc      <= '0;
            mm_ALUOut   <= '0;
            mm_store    <= '0;
        end else if (w_advance) begin
            mm_opfunc   <= flush ? '0 : ex_opfunc;
            mm_MemtoReg <= flush ? '0 : ex_MemtoReg;
            mm_RegWEN   <= ~flush & ex_RegWEN;
            mm_dWENi    <= w_new_dwen;
            mm_dRENi    <= w_new_dren;
            mm_equal    <= ~flush & ex_equal;
            mm_halt     <= ~flush & ex_halt;
            mm_rd       <= flush ? '0 : ex_rd;
            mm_portB    <= flush ? '0 : ex_portB;
            mm_npc      <= flush ? '0 : ex_npc;
            mm_ALUOut   <= flush ? '0 : ex_ALUOut;
            mm_store    <= flush ? '0 : ex_store;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: every comb output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        if (w_advance)
            w_next_state = (w_new_dren | w_new_dwen) ? REQ : IDLE;
        else if (r_state == REQ && dhit)
            w_next_state = DONE;
        else if (r_state != REQ && r_state != DONE)
            w_next_state = IDLE;
    end

    always_comb begin
        dmemREN  = 1'b0;
        dmemWEN  = 1'b0;
        mm_stall = 1'b0;
        if (r_state == REQ) begin
            dmemREN  = mm_dRENi;
            dmemWEN  = mm_dWENi;
            mm_stall = ~dhit;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)             r_loaddata <= '0;
        else if (w_load_hit) r_loaddata <= dmemload;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_stall_cnt <= '0;
        else if (mm_stall && r_stall_cnt != {CNTW{1'b1}})
            r_stall_cnt <= r_stall_cnt + CNTW'(1);
    end

    assign mm_loaddata = w_load_hit ? dmemload : r_loaddata;
    assign dmemaddr    = mm_ALUOut;
    assign dmemstore   = mm_store;
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_exmm_mem_ctrl.sv
// Bench for exmm_mem_ctrl: directed scenarios then random traffic, all checked
// against a transaction-level model of the latch, the outstanding access and the counters.
module tb_exmm_mem_ctrl;

    typedef logic [145:0] vec_t;

    typedef struct packed {
        logic [5:0]  opfunc;
        logic [1:0]  memtoreg;
        logic        regwen;
        logic        dwen;
        logic        dren;
        logic        equal;
        logic        halt;
        logic [4:0]  rd;
        logic [31:0] portb;
        logic [31:0] npc;
        logic [31:0] alu;
        logic [31:0] store;
    } ent_t;

    logic        CLK, RST, en, flush, dhit;
    logic [31:0] dmemload;
    ent_t        ex;

    logic [5:0]  mm_opfunc;
    logic [1:0]  mm_MemtoReg;
    logic        mm_RegWEN, mm_dWENi, mm_dRENi, mm_equal, mm_halt;
    logic [4:0]  mm_rd;
    logic [31:0] mm_portB, mm_npc, mm_ALUOut, mm_store;
    logic        dmemREN, dmemWEN, mm_stall;
    logic [31:0] dmemaddr, dmemstore, mm_loaddata;
    logic [15:0] stall_cnt;

    // Second instance with a narrow counter so saturation is reached quickly.
    logic [5:0]  s_opfunc;
    logic [1:0]  s_MemtoReg;
    logic        s_RegWEN, s_dWENi, s_dRENi, s_equal, s_halt;
    logic [4:0]  s_rd;
    logic [31:0] s_portB, s_npc, s_ALUOut, s_store;
    logic        s_dmemREN, s_dmemWEN, s_stall;
    logic [31:0] s_dmemaddr, s_dmemstore, s_loaddata;
    logic [3:0]  s_stall_cnt;

    exmm_mem_ctrl #(.OPW(6), .CNTW(16)) dut (
        .CLK(CLK), .RST(RST), .en(en), .flush(flush),
        .ex_opfunc(ex.opfunc), .ex_MemtoReg(ex.memtoreg), .ex_RegWEN(ex.regwen),
        .ex_dWENi(ex.dwen), .ex_dRENi(ex.dren), .ex_equal(ex.equal), .ex_halt(ex.halt),
        .ex_rd(ex.rd), .ex_portB(ex.portb), .ex_npc(ex.npc), .ex_ALUOut(ex.alu),
        .ex_store(ex.store),
        .mm_opfunc(mm_opfunc), .mm_MemtoReg(mm_MemtoReg), .mm_RegWEN(mm_RegWEN),
        .mm_dWENi(mm_dWENi), .mm_dRENi(mm_dRENi), .mm_equal(mm_equal), .mm_halt(mm_halt),
        .mm_rd(mm_rd), .mm_portB(mm_portB), .mm_npc(mm_npc), .mm_ALUOut(mm_ALUOut),
        .mm_store(mm_store),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .dhit(dhit), .dmemload(dmemload), .mm_loaddata(mm_loaddata),
        .mm_stall(mm_stall), .stall_cnt(stall_cnt)
    );

    exmm_mem_ctrl #(.OPW(6), .CNTW(4)) dut_sat (
        .CLK(CLK), .RST(RST), .en(en), .flush(flush),
        .ex_opfunc(ex.opfunc), .ex_MemtoReg(ex.memtoreg), .ex_RegWEN(ex.regwen),
        .ex_dWENi(ex.dwen), .ex_dRENi(ex.dren), .ex_equal(ex.equal), .ex_halt(ex.halt),
        .ex_rd(ex.rd), .ex_portB(ex.portb), .ex_npc(ex.npc), .ex_ALUOut(ex.alu),
        .ex_store(ex.store),
        .mm_opfunc(s_opfunc), .mm_MemtoReg(s_MemtoReg), .mm_RegWEN(s_RegWEN),
        .mm_dWENi(s_dWENi), .mm_dRENi(s_dRENi), .mm_equal(s_equal), .mm_halt(s_halt),
        .mm_rd(s_rd), .mm_portB(s_portB), .mm_npc(s_npc), .mm_ALUOut(s_ALUOut),
        .mm_store(s_store),
        .dmemREN(s_dmemREN), .dmemWEN(s_dmemWEN), .dmemaddr(s_dmemaddr),
        .dmemstore(s_dmemstore), .dhit(dhit), .dmemload(dmemload),
        .mm_loaddata(s_loaddata), .mm_stall(s_stall), .stall_cnt(s_stall_cnt)
    );

    vec_t obs_mm;
    assign obs_mm = {mm_opfunc, mm_MemtoReg, mm_RegWEN, mm_dWENi, mm_dRENi, mm_equal,
                     mm_halt, mm_rd, mm_portB, mm_npc, mm_ALUOut, mm_store};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the latched entry, whether its access is still outstanding,
    // the last load result and the total number of stalled cycles.
    ent_t        m_e;
    bit          m_pend;
    logic [31:0] m_ld;
    int          m_cnt;

    task automatic chk(input string tag, input vec_t obs, input vec_t exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_e = '0; m_pend = 0; m_ld = '0; m_cnt = 0;
    endtask

    task automatic drive(input bit e, input bit f, input ent_t x, input bit h,
                         input logic [31:0] d);
        en = e; flush = f; ex = x; dhit = h; dmemload = d;
        #1;
    endtask

    task automatic check_model();
        bit busy_stall;
        busy_stall = m_pend & ~dhit;
        chk("mm_fields", obs_mm, vec_t'(m_e));
        chk("dmemREN", vec_t'(dmemREN), vec_t'(m_pend & m_e.dren));
        chk("dmemWEN", vec_t'(dmemWEN), vec_t'(m_pend & m_e.dwen));
        chk("mm_stall", vec_t'(mm_stall), vec_t'(busy_stall));
        chk("dmemaddr", vec_t'(dmemaddr), vec_t'(m_e.alu));
        chk("dmemstore", vec_t'(dmemstore), vec_t'(m_e.store));
        chk("mm_loaddata", vec_t'(mm_loaddata),
            vec_t'((m_pend & dhit & m_e.dren) ? dmemload : m_ld));
        chk("stall_cnt", vec_t'(stall_cnt), vec_t'((m_cnt > 65535) ? 65535 : m_cnt));
        chk("stall_cnt_sat", vec_t'(s_stall_cnt), vec_t'((m_cnt > 15) ? 15 : m_cnt));
    endtask

    task automatic step();
        bit hit, stl;
        ent_t nx;
        hit = m_pend & dhit;
        stl = m_pend & ~dhit;
        if (hit && m_e.dren) m_ld = dmemload;
        if (stl) m_cnt++;
        if (en && !stl) begin
            nx = flush ? '0 : ex;
            nx.dren = nx.dren & ~nx.dwen;
            m_e = nx;
            m_pend = nx.dren | nx.dwen;
        end else if (hit) begin
            m_pend = 0;
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic cyc(input bit e, input bit f, input ent_t x, input bit h,
                       input logic [31:0] d);
        drive(e, f, x, h, d);
        check_model();
        step();
    endtask

    function automatic ent_t rand_ent();
        ent_t r;
        r = '0;
        r.opfunc = 6'($urandom); r.memtoreg = 2'($urandom);
        r.regwen = 1'($urandom); r.equal = 1'($urandom); r.halt = 1'($urandom);
        r.rd = 5'($urandom); r.portb = $urandom; r.npc = $urandom;
        r.alu = $urandom; r.store = $urandom;
        return r;
    endfunction

    function automatic ent_t mk(input bit rd_en, input bit wr_en, input logic [31:0] a,
                                input logic [31:0] s);
        ent_t r;
        r = rand_ent();
        r.dren = rd_en; r.dwen = wr_en; r.alu = a; r.store = s; r.regwen = 1'b1;
        return r;
    endfunction

    initial begin
        RST = 1'b1;
        model_reset();
        en = 0; flush = 0; ex = '0; dhit = 0; dmemload = '0;
        @(negedge CLK);
        #1;
        chk("reset_mm", obs_mm, '0);
        chk("reset_req", vec_t'({dmemREN, dmemWEN, mm_stall}), '0);
        chk("reset_ld", vec_t'(mm_loaddata), '0);
        chk("reset_cnt", vec_t'(stall_cnt), '0);
        RST = 1'b0;
        @(negedge CLK);

        // Non-memory op
        cyc(1, 0, mk(0, 0, 32'h10, 32'h0), 0, '0);
        drive(0, 0, '0, 0, '0);
        check_model();
        chk("nonmem_alu", vec_t'(mm_ALUOut), vec_t'(32'h10));
        chk("nonmem_regwen", vec_t'(mm_RegWEN), vec_t'(1'b1));
        chk("nonmem_req", vec_t'({dmemREN, dmemWEN, mm_stall}), '0);
        step();

        // Load with dhit delayed three cycles
        cyc(1, 0, mk(1, 0, 32'h40, 32'h0), 0, '0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, mk(0, 0, 32'h0, 32'h0), 0, 32'h1111_1111);
            check_model();
            chk("load_wait_ren", vec_t'(dmemREN), vec_t'(1'b1));
            chk("load_wait_stall", vec_t'(mm_stall), vec_t'(1'b1));
            chk("load_addr", vec_t'(dmemaddr), vec_t'(32'h40));
            step();
        end
        drive(1, 0, mk(0, 0, 32'h44, 32'h0), 1, 32'hDEAD_BEEF);
        check_model();
        chk("load_hit_data", vec_t'(mm_loaddata), vec_t'(32'hDEAD_BEEF));
        chk("load_hit_stall", vec_t'(mm_stall), '0);
        chk("load_stall_cnt", vec_t'(stall_cnt), vec_t'(16'd3));
        step();
        drive(0, 0, '0, 0, 32'h2222_2222);
        check_model();
        chk("load_advanced", vec_t'(mm_ALUOut), vec_t'(32'h44));
        chk("load_held", vec_t'(mm_loaddata), vec_t'(32'hDEAD_BEEF));
        step();

        // Store completing while en is low
        cyc(1, 0, mk(0, 1, 32'h80, 32'h1234), 0, '0);
        drive(0, 0, '0, 1, 32'h5555_AAAA);
        check_model();
        chk("store_wen", vec_t'(dmemWEN), vec_t'(1'b1));
        chk("store_data", vec_t'(dmemstore), vec_t'(32'h1234));
        step();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, '0, 1, 32'h6666_0000);
            check_model();
            chk("store_done_req", vec_t'({dmemREN, dmemWEN, mm_stall}), '0);
            chk("store_ld_kept", vec_t'(mm_loaddata), vec_t'(32'hDEAD_BEEF));
            step();
        end

        // Back-to-back load then store with en held high
        cyc(1, 0, mk(1, 0, 32'h100, 32'h0), 0, '0);
        drive(1, 0, mk(0, 1, 32'h200, 32'hABCD), 1, 32'hCAFE_F00D);
        check_model();
        chk("b2b_ren", vec_t'({dmemREN, dmemWEN}), vec_t'(2'b10));
        chk("b2b_addr1", vec_t'(dmemaddr), vec_t'(32'h100));
        step();
        drive(1, 0, mk(0, 0, 32'h300, 32'h0), 1, 32'h0);
        check_model();
        chk("b2b_wen", vec_t'({dmemREN, dmemWEN}), vec_t'(2'b01));
        chk("b2b_addr2", vec_t'(dmemaddr), vec_t'(32'h200));
        chk("b2b_ld", vec_t'(mm_loaddata), vec_t'(32'hCAFE_F00D));
        step();
        drive(1, 0, mk(0, 0, 32'h0, 32'h0), 0, 32'h0);
        check_model();
        chk("b2b_idle", vec_t'({dmemREN, dmemWEN, mm_stall}), '0);
        step();

        // Flush on advance
        cyc(1, 1, mk(1, 0, 32'h500, 32'h0), 1, '0);
        drive(1, 0, mk(0, 0, 32'h0, 32'h0), 1, '0);
        check_model();
        chk("flush_regwen", vec_t'(mm_RegWEN), '0);
        chk("flush_req", vec_t'({dmemREN, dmemWEN}), '0);
        step();

        // Read and write both requested: write wins
        cyc(1, 0, mk(1, 1, 32'h600, 32'h77), 0, '0);
        drive(1, 0, mk(0, 0, 32'h0, 32'h0), 0, '0);
        check_model();
        chk("both_req", vec_t'({dmemREN, dmemWEN}), vec_t'(2'b01));
        chk("both_latch_dren", vec_t'(mm_dRENi), '0);
        step();
        cyc(1, 0, mk(0, 0, 32'h0, 32'h0), 1, '0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            ent_t x;
            x = rand_ent();
            x.dren = ($urandom_range(0, 1) == 1);
            x.dwen = ($urandom_range(0, 3) == 0);
            cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), x,
                ($urandom_range(0, 2) == 0), $urandom);
        end
        chk("sat_reached", vec_t'(s_stall_cnt), vec_t'(4'hF));

        // Reset in the middle of an outstanding load
        for (int i = 0; i < 3; i++) cyc(1, 0, mk(0, 0, 32'h0, 32'h0), 1, '0);
        cyc(1, 0, mk(1, 0, 32'h900, 32'h0), 0, '0);
        drive(0, 0, '0, 0, '0);
        check_model();
        chk("midreq_ren", vec_t'(dmemREN), vec_t'(1'b1));
        RST = 1'b1;
        #1;
        chk("rst_async_req", vec_t'({dmemREN, dmemWEN, mm_stall}), '0);
        chk("rst_async_mm", obs_mm, '0);
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
        drive(0, 0, '0, 1, '0);
        check_model();
        chk("rst_cnt", vec_t'(stall_cnt), '0);
        chk("rst_idle", vec_t'({dmemREN, dmemWEN, mm_stall}), '0);
        step();
        cyc(1, 0, mk(0, 0, 32'h0, 32'h0), 0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
